// File: rtl/dm_responder.sv
// Word-addressed data-memory responder with fixed wait states and a one-cycle ack strobe.
// Optional misaligned-address error response is enabled by defining DM_ALIGN_CHECK_EN.
module dm_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  dbg_state_o
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q;
  logic        load;
  logic        enter_resp;

  logic        acc_we;
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_misalign, rsp_misalign;
  logic        acc_bad, rsp_bad;
  logic [31:0] rd_word;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          load = 1'b1;
          if (WAIT_LD == 4'd0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end
      end
      S_RESP: begin
        // The strobe is registered, so it appears on the edge leaving RESP.
        state_d = S_IDLE;
        ack_d   = 1'b1;
        err_d   = rsp_bad;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the accepting edge, before the latch holds the request.
  assign acc_we     = load ? we    : we_q;
  assign acc_addr   = load ? addr  : addr_q;
  assign acc_wdata  = load ? wdata : wdata_q;
  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

`ifdef DM_ALIGN_CHECK_EN
  assign acc_misalign = |acc_addr[1:0];
  assign rsp_misalign = |addr_q[1:0];
`else
  logic unused_offset;
  assign unused_offset = ^{acc_addr[1:0], addr_q[1:0]};
  assign acc_misalign  = 1'b0;
  assign rsp_misalign  = 1'b0;
`endif

  assign acc_bad = (acc_addr[31:2] >= DEPTH_W) || acc_misalign;
  assign rsp_bad = (addr_q[31:2] >= DEPTH_W) || rsp_misalign;
  assign rd_word = mem[acc_addr[AW+1:2]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (load) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (enter_resp) begin
        if (acc_bad) begin
          rdata_q <= 32'd0;
        end else if (!acc_we) begin
          rdata_q <= rd_word;
        end
      end
    end
  end

  // Storage is deliberately not reset; an aborted transaction never reaches enter_resp.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && !acc_bad) begin
      mem[acc_addr[AW+1:2]] <= acc_wdata;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign ack         = ack_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: unit 0 uses default parameters, unit 1 has zero wait states.
// Responses are checked by a monitor popping expected {err, rdata} entries on every ack.
module tb_dm_responder;

  logic        clk;
  logic        rst;
  logic        req_v   [2];
  logic        we_v    [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic        busy_v  [2];
  logic        ack_v   [2];
  logic [31:0] rdata_v [2];
  logic        err_v   [2];
  logic [1:0]  st_v    [2];

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];

  int checks;
  int errors;

  dm_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]),
    .busy(busy_v[0]), .ack(ack_v[0]), .rdata(rdata_v[0]), .err(err_v[0]), .dbg_state_o(st_v[0])
  );

  dm_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]),
    .busy(busy_v[1]), .ack(ack_v[1]), .rdata(rdata_v[1]), .err(err_v[1]), .dbg_state_o(st_v[1])
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Monitor: compare every response strobe with the oldest expectation
  always @(negedge clk) begin
    if (!rst && ack_v[0] === 1'b1) begin
      if (exp_q0.size() == 0) check("resp0_unexpected", {err_v[0], rdata_v[0]}, 33'h1_DEAD_BEEF);
      else check("resp0", {err_v[0], rdata_v[0]}, exp_q0.pop_front());
    end
    if (!rst && ack_v[1] === 1'b1) begin
      if (exp_q1.size() == 0) check("resp1_unexpected", {err_v[1], rdata_v[1]}, 33'h1_DEAD_BEEF);
      else check("resp1", {err_v[1], rdata_v[1]}, exp_q1.pop_front());
    end
  end

  // Driver: issue one request, push its expected response, then scramble the inputs while
  // the transaction is pending and measure ack latency and busy duration.
  task automatic txn(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic e, input logic [31:0] r);
    int lat;
    int nb;
    int wc;
    wc = (u == 0) ? 2 : 0;
    @(negedge clk);
    req_v[u]   = 1'b1;
    we_v[u]    = w;
    addr_v[u]  = a;
    wdata_v[u] = d;
    if (u == 0) exp_q0.push_back({e, r});
    else exp_q1.push_back({e, r});
    @(posedge clk); #1;
    req_v[u]   = 1'b0;
    we_v[u]    = 1'b1;
    addr_v[u]  = a + 32'd4;
    wdata_v[u] = 32'h77;
    lat = 0;
    nb  = 0;
    while (lat < 20) begin
      if (busy_v[u]) nb++;
      if (ack_v[u]) break;
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("ack_latency%0d", u), 33'(lat), 33'(wc + 1));
    check($sformatf("busy_cycles%0d", u), 33'(nb), 33'(wc + 1));
  endtask

  task automatic check_idle(input string tag);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("%s_busy%0d", tag, u), {32'd0, busy_v[u]}, 33'd0);
      check($sformatf("%s_ack%0d", tag, u), {32'd0, ack_v[u]}, 33'd0);
      check($sformatf("%s_err%0d", tag, u), {32'd0, err_v[u]}, 33'd0);
      check($sformatf("%s_rdata%0d", tag, u), {1'b0, rdata_v[u]}, 33'd0);
      check($sformatf("%s_state%0d", tag, u), {31'd0, st_v[u]}, 33'd0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_v[u]   = 1'b0;
      we_v[u]    = 1'b0;
      addr_v[u]  = 32'd0;
      wdata_v[u] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b0;

    // Unit 0, WAIT_CYCLES=2
    txn(0, 1'b1, 32'h10,  32'h0000_00AA, 1'b0, 32'h0);
    txn(0, 1'b0, 32'h10,  32'h0,         1'b0, 32'h0000_00AA);
    txn(0, 1'b1, 32'h24,  32'h2424_2424, 1'b0, 32'h0000_00AA);
    txn(0, 1'b1, 32'h20,  32'h0000_0055, 1'b0, 32'h0000_00AA);
    txn(0, 1'b0, 32'h20,  32'h0,         1'b0, 32'h0000_0055);
    txn(0, 1'b0, 32'h24,  32'h0,         1'b0, 32'h2424_2424);
    txn(0, 1'b1, 32'h0,   32'h0000_C0DE, 1'b0, 32'h2424_2424);
    txn(0, 1'b0, 32'h100, 32'h0,         1'b1, 32'h0);
    txn(0, 1'b1, 32'h100, 32'h0000_DEAD, 1'b1, 32'h0);
    txn(0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0000_C0DE);
`ifdef DM_ALIGN_CHECK_EN
    txn(0, 1'b1, 32'h13,  32'h0000_0099, 1'b1, 32'h0);
    txn(0, 1'b0, 32'h10,  32'h0,         1'b0, 32'h0000_00AA);
    txn(0, 1'b1, 32'h8,   32'h0000_0011, 1'b0, 32'h0000_00AA);
`else
    txn(0, 1'b1, 32'h13,  32'h0000_0099, 1'b0, 32'h0000_C0DE);
    txn(0, 1'b0, 32'h10,  32'h0,         1'b0, 32'h0000_0099);
    txn(0, 1'b1, 32'h8,   32'h0000_0011, 1'b0, 32'h0000_0099);
`endif

    // Unit 1, WAIT_CYCLES=0
    txn(1, 1'b1, 32'h0,   32'h1234_5678, 1'b0, 32'h0);
    txn(1, 1'b0, 32'h0,   32'h0,         1'b0, 32'h1234_5678);

    // Abort a pending write with reset one cycle after acceptance
    @(negedge clk);
    req_v[0]   = 1'b1;
    we_v[0]    = 1'b1;
    addr_v[0]  = 32'h8;
    wdata_v[0] = 32'h0000_00FF;
    @(posedge clk); #1;
    req_v[0] = 1'b0;
    check("abort_busy_before", {32'd0, busy_v[0]}, 33'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_idle("abort");
    @(negedge clk);
    rst = 1'b0;

    txn(0, 1'b0, 32'h8,   32'h0,         1'b0, 32'h0000_0011);
    txn(0, 1'b1, 32'hFC,  32'h0000_3F3F, 1'b0, 32'h0000_0011);
    txn(0, 1'b0, 32'hFC,  32'h0,         1'b0, 32'h0000_3F3F);
    txn(1, 1'b0, 32'h0,   32'h0,         1'b0, 32'h1234_5678);

    repeat (5) @(posedge clk);
    #1;
    check("drain0", 33'(exp_q0.size()), 33'd0);
    check("drain1", 33'(exp_q1.size()), 33'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, meaning the number of 32-bit words stored (word index = addr[31:2]).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted between request acceptance and response (legal range 0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, 1 bit: request valid from the datapath (MemRead/MemWrite side).
REQ-006 SHALL have port we, input, 1 bit: 1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port addr, input, 32 bits: byte address (ALU result z).
REQ-008 SHALL have port wdata, input, 32 bits: store data (rd2).
REQ-009 SHALL have port busy, output, 1 bit: high whenever a request is in progress.
REQ-010 SHALL have port ack, output, 1 bit: one-cycle response strobe.
REQ-011 SHALL have port rdata, output, 32 bits: read data (memOut).
REQ-012 SHALL have port err, output, 1 bit: error flag, valid only while ack is high.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and RESP; busy = (state != IDLE).
REQ-014 SHALL sample req only in IDLE; on a rising edge with req=1, SHALL latch we, addr and wdata.
REQ-015 On acceptance, SHALL go to WAIT with the wait counter loaded to WAIT_CYCLES, or go directly to RESP if WAIT_CYCLES=0.
REQ-016 In WAIT, SHALL decrement the counter each edge and go to RESP on the edge where the counter reaches 0.
REQ-017 Latency: SHALL raise ack exactly WAIT_CYCLES+1 edges after the accepting edge, hold it for exactly one cycle, then return to IDLE.
REQ-018 SHALL ignore req, we, addr and wdata in WAIT and RESP; input changes there SHALL NOT affect the pending transaction.
REQ-019 Throughput: SHALL accept at most one request per WAIT_CYCLES+2 cycles.
REQ-020 Write: SHALL update the memory word on the edge entering RESP, with rdata unchanged.
REQ-021 Read: SHALL load rdata on the edge entering RESP with the addressed word; rdata SHALL hold until the next read or error response.
REQ-022 Out-of-range (word index >= DEPTH_WORDS): SHALL respond with err=1 and rdata=0 and perform no write.
REQ-023 A write followed by a read of the same word SHALL return the written data.
REQ-024 Memory contents SHALL NOT be reset and SHALL be undefined until first written.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, counter=0, busy=0, ack=0, err=0 and rdata=0, regardless of clk.
REQ-026 Reset during WAIT SHALL abort the transaction: no write occurs and no ack follows.
REQ-027 After rst deasserts, the first rising edge with req=1 SHALL be accepted normally.

Configuration
REQ-028 Macro DM_ALIGN_CHECK_EN defined: a request with addr[1:0] != 0 SHALL complete with normal latency, err=1, rdata=0 and no write.
REQ-029 Macro DM_ALIGN_CHECK_EN undefined: addr[1:0] SHALL be ignored and such a request SHALL access word addr[31:2] with err=0.
REQ-030 Range checking (REQ-022) SHALL be present in both configurations.

Verification
REQ-031 Default parameters: write 0x000000AA to addr 0x10, then read addr 0x10 -> each ack arrives 3 edges after acceptance; the read returns rdata=0x000000AA with err=0.
REQ-032 WAIT_CYCLES=0: read addr 0x0 after writing 0x12345678 -> ack arrives on the edge after acceptance with rdata=0x12345678; busy is high for exactly 1 cycle.
REQ-033 Default parameters: accept a write of 0x55 to 0x20, then change addr to 0x24 and wdata to 0x77 during WAIT; read 0x20 and 0x24 -> 0x20 returns 0x55 and 0x24 is unchanged.
REQ-034 Read addr 0x100 (word 64, DEPTH_WORDS=64) -> ack with err=1 and rdata=0; a write to 0x100 leaves word 0 unchanged.
REQ-035 Assert rst one cycle after accepting a write of 0xFF to 0x8 -> busy and ack drop immediately; a later read of 0x8 returns the prior value, not 0xFF.
REQ-036 DM_ALIGN_CHECK_EN defined: write to addr 0x13 -> err=1, and word 4 is unchanged. Macro undefined: the same write -> err=0, and word 4 = written data.
